// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel arbitrated output mux.
// Holds the channel-index width helper and the arbitration mode names.
package mux_pkg;

    localparam int MAX_NCH = 16;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Index width for n channels, never narrower than one bit
    function automatic int selw_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed lowest-index.
// Produces a one-hot grant, its encoded index and an any-request flag.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int    NCH  = 4,
    parameter bit    RR   = 1'b1,
    localparam int   SELW = selw_f(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] idx,
    output logic            any_req
);

    // Channel examined at search step k
    function automatic logic [SELW-1:0] cand(
        input int              k,
        input logic [SELW-1:0] p
    );
        int unsigned c;
        if (RR) begin
            c = (32'(p) + 32'(k)) % 32'(NCH);
        end else begin
            c = 32'(k);
        end
        return SELW'(c);
    endfunction

    // First requester found in search order wins
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!any_req && req[cand(k, ptr)]) begin
                any_req             = 1'b1;
                idx                 = cand(k, ptr);
                grant[cand(k, ptr)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// Registered N:1 mux with per-channel valid/ready and arbitration.
// One-entry output register; push and pop may share a cycle.
module arb_mux_n
    import mux_pkg::*;
#(
    parameter int    WIDTH = 32,
    parameter int    NCH   = 4,
    parameter bit    RR    = 1'b1,
    localparam int   SELW  = selw_f(NCH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_sel,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  gnt_idx;
    logic             any_req;

    logic [SELW-1:0]  ptr_q;
    logic [SELW-1:0]  ptr_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [SELW-1:0]  out_sel_q;
    logic [SELW-1:0]  out_sel_d;

    logic [WIDTH-1:0] sel_data;
    logic             free;
    logic             push;

    rr_arbiter #(
        .NCH (NCH),
        .RR  (RR)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .grant   (grant),
        .idx     (gnt_idx),
        .any_req (any_req)
    );

    // Handshake: accept only into a free output register
    always_comb begin
        free     = !out_valid_q || out_ready;
        push     = free && any_req;
        in_ready = (free && !RST) ? grant : '0;
    end

    // Payload of the granted channel
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and pointer next state
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (push) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = gnt_idx;
            if (RR) begin
                if (gnt_idx == SELW'(NCH - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gnt_idx + SELW'(1);
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (!RR) begin
            ptr_d = '0;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: RR, fixed-priority and single-channel instances
// against a per-instance reference model plus directed literal checks.
module tb_arb_mux_n;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [3:0]   v0, rdy0, v1, rdy1;
    logic [127:0] d0, d1;
    logic         r0, r1, r2, ov0, ov1, ov2;
    logic [31:0]  od0, od1;
    logic [1:0]   os0, os1;
    logic [0:0]   v2, rdy2, os2;
    logic [7:0]   d2, od2;

    arb_mux_n #(.WIDTH(32), .NCH(4), .RR(1'b1)) dut_rr (
        .CLK(CLK), .RST(RST), .in_data(d0), .in_valid(v0),
        .in_ready(rdy0), .out_data(od0), .out_sel(os0),
        .out_valid(ov0), .out_ready(r0)
    );

    arb_mux_n #(.WIDTH(32), .NCH(4), .RR(1'b0)) dut_fp (
        .CLK(CLK), .RST(RST), .in_data(d1), .in_valid(v1),
        .in_ready(rdy1), .out_data(od1), .out_sel(os1),
        .out_valid(ov1), .out_ready(r1)
    );

    arb_mux_n #(.WIDTH(8), .NCH(1), .RR(1'b1)) dut_one (
        .CLK(CLK), .RST(RST), .in_data(d2), .in_valid(v2),
        .in_ready(rdy2), .out_data(od2), .out_sel(os2),
        .out_valid(ov2), .out_ready(r2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state per instance: 0 = rr, 1 = fixed, 2 = single
    int          nch[3] = '{4, 4, 1};
    bit          rrm[3] = '{1'b1, 1'b0, 1'b1};
    int          m_ptr[3];
    bit          m_vld[3];
    logic [31:0] m_dat[3];
    int          m_sel[3];

    function automatic logic [15:0] vin(int i);
        case (i)
            0:       return 16'(v0);
            1:       return 16'(v1);
            default: return 16'(v2);
        endcase
    endfunction

    function automatic logic [31:0] din(int i, int c);
        case (i)
            0:       return d0[c*32 +: 32];
            1:       return d1[c*32 +: 32];
            default: return {24'h0, d2};
        endcase
    endfunction

    function automatic bit rin(int i);
        case (i)
            0:       return r0;
            1:       return r1;
            default: return r2;
        endcase
    endfunction

    function automatic int winner(int i);
        logic [15:0] v;
        int c;
        v = vin(i);
        for (int k = 0; k < nch[i]; k++) begin
            c = rrm[i] ? (m_ptr[i] + k) % nch[i] : k;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit mfree(int i);
        return !m_vld[i] || rin(i);
    endfunction

    function automatic logic [15:0] exp_rdy(int i);
        int g;
        if (RST) return 16'h0;
        g = winner(i);
        if (mfree(i) && g >= 0) return 16'h1 << g;
        return 16'h0;
    endfunction

    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < 3; i++) begin
            if (RST) begin
                m_ptr[i] <= 0;
                m_vld[i] <= 1'b0;
                m_dat[i] <= 32'h0;
                m_sel[i] <= 0;
            end else if (mfree(i) && winner(i) >= 0) begin
                m_vld[i] <= 1'b1;
                m_dat[i] <= din(i, winner(i));
                m_sel[i] <= winner(i);
                if (rrm[i]) m_ptr[i] <= (winner(i) + 1) % nch[i];
            end else if (rin(i)) begin
                m_vld[i] <= 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        chk("ov_rr", 32'(ov0), 32'(m_vld[0]));
        chk("od_rr", od0, m_dat[0]);
        chk("os_rr", 32'(os0), 32'(m_sel[0]));
        chk("rdy_rr", 32'(rdy0), 32'(exp_rdy(0)));
        chk("oh_rr", 32'($countones(rdy0) > 1), 32'h0);
        chk("ov_fp", 32'(ov1), 32'(m_vld[1]));
        chk("od_fp", od1, m_dat[1]);
        chk("os_fp", 32'(os1), 32'(m_sel[1]));
        chk("rdy_fp", 32'(rdy1), 32'(exp_rdy(1)));
        chk("ov_one", 32'(ov2), 32'(m_vld[2]));
        chk("od_one", 32'(od2), m_dat[2]);
        chk("os_one", 32'(os2), 32'h0);
        chk("rdy_one", 32'(rdy2), 32'(exp_rdy(2)));
    end

    logic [3:0] acc0, acc1;
    logic       acc2;
    int         sent;
    logic [7:0] got[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0;
        v0 = '0; v1 = '0; v2 = '0;
        d0 = '0; d1 = '0; d2 = '0;
        r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;
        chk("rst_ov", 32'(ov0), 32'h0);
        chk("rst_od", od0, 32'h0);
        chk("rst_ptr", 32'(dut_rr.ptr_q), 32'h0);

        // Mid-stream reset with a word held in the output register
        tick();
        v0 = 4'b0001;
        d0 = {96'h0, 32'hDEAD_BEEF};
        tick();
        chk("pre_ov", 32'(ov0), 32'h1);
        chk("pre_od", od0, 32'hDEAD_BEEF);
        v0 = '0;
        #2 RST = 1'b1;
        #1;
        chk("arst_ov", 32'(ov0), 32'h0);
        chk("arst_od", od0, 32'h0);
        chk("arst_os", 32'(os0), 32'h0);
        chk("arst_ptr", 32'(dut_rr.ptr_q), 32'h0);
        v0 = 4'b1111;
        d0 = {32'h103, 32'h102, 32'h101, 32'h100};
        r0 = 1'b1;
        #3 RST = 1'b0;

        // Round-robin rotation with all channels requesting
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_sel", 32'(os0), 32'(i % 4));
            chk("rr_dat", od0, 32'h100 + 32'(i % 4));
        end
        v0 = '0;
        tick();

        // Fixed priority: channel 1 always beats channel 3
        v1 = 4'b1010;
        d1 = {32'h33, 32'h0, 32'h11, 32'h0};
        r1 = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("fp_rdy", 32'(rdy1), 32'h2);
            tick();
            chk("fp_sel", 32'(os1), 32'h1);
            chk("fp_dat", od1, 32'h11);
        end
        v1 = '0;

        // Backpressure holds word and pointer
        v0 = 4'b0100;
        d0 = {32'h0, 32'hA5, 32'h0, 32'h0};
        r0 = 1'b0;
        tick();
        chk("bp_ptr0", 32'(dut_rr.ptr_q), 32'h3);
        v0 = 4'b1111;
        d0 = {32'h203, 32'hA6, 32'h201, 32'h200};
        repeat (4) begin
            @(negedge CLK);
            chk("bp_rdy", 32'(rdy0), 32'h0);
            tick();
            chk("bp_dat", od0, 32'hA5);
            chk("bp_sel", 32'(os0), 32'h2);
            chk("bp_ptr", 32'(dut_rr.ptr_q), 32'h3);
        end
        r0 = 1'b1;
        @(negedge CLK);
        chk("bp_rel_rdy", 32'(rdy0), 32'h8);
        tick();
        chk("bp_rel_sel", 32'(os0), 32'h3);
        chk("bp_rel_dat", od0, 32'h203);

        // Sparse traffic with pointer wrap
        v0 = 4'b0010;
        tick();
        chk("sp_ptr2", 32'(dut_rr.ptr_q), 32'h2);
        v0 = 4'b0001;
        @(negedge CLK);
        chk("sp_rdy", 32'(rdy0), 32'h1);
        tick();
        chk("sp_sel", 32'(os0), 32'h0);
        chk("sp_dat", od0, 32'h200);
        chk("sp_ptr1", 32'(dut_rr.ptr_q), 32'h1);
        v0 = '0;
        tick();
        chk("sp_idle_ptr", 32'(dut_rr.ptr_q), 32'h1);
        chk("sp_idle_ov", 32'(ov0), 32'h0);

        // Random traffic; single-channel instance streams 1..16
        acc0 = '0; acc1 = '0; acc2 = 1'b0;
        sent = 1;
        for (int n = 0; n < 400; n++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            r2 = $urandom_range(0, 1) == 1;
            for (int c = 0; c < 4; c++) begin
                if (acc0[c] || !v0[c]) begin
                    v0[c] = ($urandom_range(0, 3) != 0);
                    d0[c*32 +: 32] = $urandom;
                end
                if (acc1[c] || !v1[c]) begin
                    v1[c] = ($urandom_range(0, 2) != 0);
                    d1[c*32 +: 32] = $urandom;
                end
            end
            if (acc2) sent++;
            v2 = (sent <= 16) ? 1'b1 : 1'b0;
            d2 = 8'(sent);
            @(negedge CLK);
            acc0 = v0 & rdy0;
            acc1 = v1 & rdy1;
            acc2 = v2[0] & rdy2[0];
            if (ov2 && r2) got.push_back(od2);
            tick();
        end
        v0 = '0; v1 = '0; v2 = '0;
        r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (ov2 && r2) got.push_back(od2);
            tick();
        end
        chk("one_cnt", 32'(got.size()), 32'd16);
        foreach (got[k]) begin
            chk("one_ord", 32'(got[k]), 32'(k + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-channel successor to the two-input selector: a registered N:1 multiplexer with per-channel valid/ready handshakes and built-in arbitration. It merges requests from several producers in the pipelined core into one consumer, such as instruction and data requests onto one memory port, or several writeback sources onto one port. Output is a one-entry pipeline register, so the block sustains one transfer per cycle with one cycle of latency.

## Interface
- WIDTH, 32, payload width in bits.
- NCH, 4, number of input channels; legal range 1–16.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SELW, $clog2(NCH) (minimum 1), width of the channel-index field; derived, do not override.
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_data  input  NCH×WIDTH  per-channel payload, packed with channel i at bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel request.
- in_ready  output  NCH  per-channel accept; at most one bit is high in any cycle.
- out_data  output  WIDTH  registered payload.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

## Operation
- Output register is free when !out_valid || out_ready.
- Arbitration:
  - Among asserted in_valid bits, pick the winner g.
  - RR=1: search starts at pointer ptr and wraps modulo NCH.
  - RR=0: lowest asserted index wins; ptr is unused and stays 0.
- Acceptance:
  - in_ready[g] = 1 only when the output register is free; all other in_ready bits are 0.
  - A transfer on channel g occurs when in_valid[g] && in_ready[g].
- On a transfer: out_data <= in_data[g], out_sel <= g, out_valid <= 1, and (RR=1) ptr <= (g+1) mod NCH.
- If out_valid && out_ready and no input transfers, out_valid <= 0. out_data and out_sel keep their last values.
- Simultaneous pop and push in one cycle: the new word replaces the old one and out_valid stays 1. Full throughput, no bubble.
- No asserted in_valid: ptr is unchanged and every in_ready bit is 0.
- Stall (out_valid && !out_ready): out_data, out_sel and ptr are held stable; all in_ready bits are 0.
- Producers must hold in_valid and in_data until accepted. The block never drops or duplicates a word.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is all zeros while RST is high.
- Assertion of RST is asynchronous. Any word held in the output register is discarded; no partial transfer survives.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k and can be consumed at edge k+1.
- Combinational paths:
  - in_ready depends on in_valid, ptr, out_valid and out_ready.
  - No combinational path from any input to out_data, out_valid or out_sel.
- Fairness (RR=1): a continuously requesting channel waits at most NCH−1 transfers.
- Pointer wrap: g = NCH−1 sets ptr to 0.
- NCH=1: the block degenerates to a single-entry pipeline register, and out_sel is always 0.

## Structure
- Shared package mux_pkg holds the SELW derivation function (clog2 with a minimum of 1) and an arb_mode_e enum (ARB_FIXED, ARB_RR) for documentation use.
- Sub-module rr_arbiter #(NCH, RR):
  - Inputs: request vector, ptr.
  - Outputs: one-hot grant, encoded index g, any_req.
  - Purely combinational.
- arb_mux_n owns ptr, the output register and the handshake logic.

## Test plan
- Reset mid-stream: drive out_valid=1 with out_data=0xDEAD_BEEF, then pulse RST between edges. Outputs go to 0 immediately with no clock edge, and ptr returns to 0.
- Round-robin, NCH=4, all in_valid=1, out_ready=1, in_data[i]=0x100+i for 8 cycles. out_sel sequence is 0,1,2,3,0,1,2,3 and out_data tracks it; in_ready is one-hot every cycle.
- Fixed priority, RR=0, in_valid=4'b1010 held for 3 cycles. Channel 1 wins every cycle and channel 3 is never granted.
- Backpressure: channel 2 sends 0xA5 and out_ready=0 for 4 cycles. out_data stays 0xA5, in_ready stays 0, ptr is unchanged. After out_ready=1 the next grant goes to channel 3.
- Sparse traffic: in_valid=4'b0001 only, ptr=2. Channel 0 is granted after wrapping and ptr becomes 1. One idle cycle later, ptr is still 1.
- NCH=1, WIDTH=8, back-to-back stream 0x01..0x10 with random out_ready. Output order and count match input exactly, with no loss or duplicate.
